imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the 64x32 instruction memory: accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one write per word into the instruction memory write port at consecutive word offsets, starting at offset 0.
- Holds the pipeline in reset/stall (cpu_hold) while a program image is being loaded.
- Sits between the boot/debug byte source (UART or testbench) and the instruction memory.

Parameters:
- ADDR_W, 6, word-offset width (matches the 6-bit instruction memory offset).
- DEPTH, 64, number of 32-bit words in instruction memory.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- word_count  in  ADDR_W+1  words to load; latched on accepted start.
- abort  in  1  cancel current load; no further writes.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word offset being written.
- wr_data  out  32  assembled word.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse: load completed normally.
- cpu_hold  out  1  equals busy; pipeline holds PC/fetch while high.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - byte_ready, wr_en, busy, done, cpu_hold = 0.
  - wr_addr = 0, wr_data = 0.
  - Byte counter, word counter and latched count cleared.
- All outputs are registered.
- States: IDLE, LOAD, WRITE, FIN.
- IDLE:
  - On start=1: latch N = min(word_count, DEPTH) and go to LOAD, with busy=1 from the next cycle.
  - If N=0, go to FIN instead; no writes occur.
  - start is ignored in all other states.
- LOAD:
  - byte_ready=1.
  - A byte transfers on a rising edge with byte_valid & byte_ready.
  - Byte k (k=0..3) is placed in wr_data[8k+7:8k]; first byte is the LSB.
  - On the 4th transfer, go to WRITE.
  - byte_valid=0 stalls indefinitely with no timeout.
- WRITE (exactly 1 cycle):
  - byte_ready=0, wr_en=1, wr_addr = current word index, wr_data = assembled word.
  - Next state: FIN if word index == N-1; otherwise increment the word index, clear the byte counter, and go to LOAD.
- Latency: wr_en is high in the cycle immediately after the edge that accepted the 4th byte. Maximum throughput is 4 bytes per 5 cycles.
- FIN (1 cycle):
  - done=1, busy=0, cpu_hold=0 on exit.
  - Next state: IDLE.
  - Bytes are not accepted.
- Word index wrap: cannot occur, because N ≤ DEPTH. word_count > DEPTH clamps to DEPTH (64 words written, offsets 0..63).
- abort=1 in LOAD or WRITE:
  - Next state is IDLE; done is not asserted.
  - A write already being presented in the WRITE cycle completes (wr_en stays high that cycle). No later writes occur.
  - A partially assembled word is discarded.
- abort in IDLE/FIN: no effect.
- abort together with a 4th-byte handshake: abort wins; the byte is consumed and no write occurs.
- wr_en=0 in every state except WRITE. wr_addr and wr_data hold their last values otherwise.
- rst_n asserted mid-load: immediate return to reset values; memory contents already written are untouched.

Test Plan:
- Reset: rst_n=0 mid-LOAD (after 2 bytes) → all outputs 0 asynchronously; after release, start with word_count=1 loads a fresh word from byte 0.
- Single word: start, word_count=1, bytes 83,00,00,00 back-to-back → one wr_en at wr_addr=0, wr_data=0x00000083, then done pulse; busy high 6 cycles.
- Four words, back-to-back: bytes for 0x00000083, 0x00400103, 0x00F0D193, 0x0020D213 → wr_en at addr 0..3 with those words; done follows the addr 3 write; byte_ready low during each WRITE cycle.
- Gapped valid: same 0x00F0D193 word with byte_valid low 3 cycles between bytes → identical write, no extra wr_en.
- Boundaries:
  - word_count=0 → done next-but-one cycle with no wr_en.
  - word_count=100 → exactly 64 writes, last at addr 63.
  - start while busy → ignored.
- Abort: abort after 2 words plus 2 bytes of the third → writes only at addr 0 and 1, no done; the next start begins again at addr 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              cpu_hold;

  // Byte source / controller side.
  modport master (
    output start, word_count, abort, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold
  );

  // Loader side.
  modport slave (
    input  start, word_count, abort, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: assembles little-endian 32-bit words from a
// byte stream and writes them to consecutive word offsets from 0, holding
// the CPU while a program image is loaded.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_FIN
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W-1:0] r_word_idx;
  logic [1:0]        r_byte_cnt;
  logic [2:0][7:0]   r_asm;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_byte_ready, r_wr_en, r_busy, r_done;

  logic [ADDR_W:0]   w_clamp;
  logic              w_xfer;
  logic              w_last;

  assign w_clamp = (bus.word_count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH)
                                                        : bus.word_count;
  // byte_ready is high exactly while in LOAD, so the state alone qualifies it.
  assign w_xfer  = (r_state == S_LOAD) && bus.byte_valid;
  assign w_last  = ({1'b0, r_word_idx} == (r_n - (ADDR_W+1)'(1)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort outranks a completing word.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = (w_clamp == '0) ? S_FIN : S_LOAD;
      end
      S_LOAD: begin
        if (bus.abort)                          w_next = S_IDLE;
        else if (w_xfer && r_byte_cnt == 2'd3) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (bus.abort)   w_next = S_IDLE;
        else if (w_last) w_next = S_FIN;
        else             w_next = S_LOAD;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Count latch, byte assembly and write address/data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n        <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_n        <= w_clamp;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_asm[0] <= bus.byte_in;
              2'd1: r_asm[1] <= bus.byte_in;
              2'd2: r_asm[2] <= bus.byte_in;
              default: begin
                // Output word is captured here so wr_data/wr_addr hold
                // steady outside the WRITE cycle.
                if (!bus.abort) begin
                  r_wr_data <= {bus.byte_in, r_asm};
                  r_wr_addr <= r_word_idx;
                end
              end
            endcase
          end
        end
        S_WRITE: begin
          if (!bus.abort && !w_last) begin
            r_word_idx <= r_word_idx + ADDR_W'(1);
            r_byte_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Control outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_byte_ready <= (w_next == S_LOAD);
      r_wr_en      <= (w_next == S_WRITE);
      r_busy       <= (w_next != S_IDLE);
      r_done       <= (w_next == S_FIN);
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.cpu_hold   = r_busy;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle-exact vector table plus
// directed multi-word, clamp, abort and reset sequences.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  imem_loader_if #(.ADDR_W(6)) bus ();

  imem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write / done monitor, sampled on the falling edge.
  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t wq[$];
  int done_cnt = 0, ovl_cnt = 0, cyc = 0, last_wr_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.wr_en) begin
      wq.push_back('{bus.wr_addr, bus.wr_data});
      last_wr_cyc <= cyc;
      if (bus.byte_ready) ovl_cnt <= ovl_cnt + 1;
    end
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  function automatic logic [63:0] outs();
    return {21'd0, bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
            bus.busy, bus.done, bus.cpu_hold};
  endfunction

  // Cycle vectors: inputs driven at negedge, outputs checked 1 time unit
  // after the following rising edge.
  typedef struct {
    logic        st;
    logic [6:0]  wc;
    logic        ab;
    logic [7:0]  b;
    logic        v;
    logic        e_rdy;
    logic        e_wen;
    logic [5:0]  e_addr;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_done;
  } vec_t;
  vec_t vec[14];

  task automatic idle_inputs();
    bus.start = 1'b0; bus.word_count = '0; bus.abort = 1'b0;
    bus.byte_in = '0; bus.byte_valid = 1'b0;
  endtask

  // All tasks below begin and end at a falling edge.
  task automatic do_start(input logic [6:0] wc);
    bus.start = 1'b1; bus.word_count = wc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    int   t;
    for (int g = 0; g < gap; g++) begin
      bus.byte_valid = 1'b0;
      @(negedge clk);
    end
    bus.byte_in = b; bus.byte_valid = 1'b1;
    ok = 1'b0; t = 0;
    while (!ok && t < 40) begin
      ok = bus.byte_ready;
      @(negedge clk);
      t++;
    end
    if (!ok) chk("byte handshake timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], (k == 0) ? 0 : gap);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    bus.byte_valid = 1'b0;
    while (bus.busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({name, " return to idle"}, 64'(bus.busy), 64'd0);
  endtask

  logic [31:0] words4[4] = '{32'h00000083, 32'h00400103, 32'h00F0D193, 32'h0020D213};
  int base, d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              st wc    ab b      v  rdy wen addr data            busy done
    vec[0]  = '{1, 7'd1, 0, 8'h00, 0, 1, 0, 6'd0, 32'h00000000, 1, 0};
    vec[1]  = '{0, 7'd0, 0, 8'h83, 1, 1, 0, 6'd0, 32'h00000000, 1, 0};
    vec[2]  = '{0, 7'd0, 0, 8'h00, 1, 1, 0, 6'd0, 32'h00000000, 1, 0};
    vec[3]  = '{0, 7'd0, 0, 8'h00, 1, 1, 0, 6'd0, 32'h00000000, 1, 0};
    vec[4]  = '{0, 7'd0, 0, 8'h00, 1, 0, 1, 6'd0, 32'h00000083, 1, 0};
    vec[5]  = '{0, 7'd0, 0, 8'h00, 0, 0, 0, 6'd0, 32'h00000083, 1, 1};
    vec[6]  = '{0, 7'd0, 0, 8'h00, 0, 0, 0, 6'd0, 32'h00000083, 0, 0};
    vec[7]  = '{1, 7'd2, 0, 8'h00, 0, 1, 0, 6'd0, 32'h00000083, 1, 0};
    vec[8]  = '{0, 7'd0, 0, 8'h13, 1, 1, 0, 6'd0, 32'h00000083, 1, 0};
    vec[9]  = '{0, 7'd0, 0, 8'h01, 1, 1, 0, 6'd0, 32'h00000083, 1, 0};
    vec[10] = '{0, 7'd0, 0, 8'h40, 1, 1, 0, 6'd0, 32'h00000083, 1, 0};
    vec[11] = '{0, 7'd0, 0, 8'h00, 1, 0, 1, 6'd0, 32'h00400113, 1, 0};
    vec[12] = '{0, 7'd0, 1, 8'h00, 0, 0, 0, 6'd0, 32'h00400113, 0, 0};
    vec[13] = '{0, 7'd0, 0, 8'h00, 0, 0, 0, 6'd0, 32'h00400113, 0, 0};

    idle_inputs();
    #2 rst_n = 1'b0;
    #2 chk("reset outputs", outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cycle-exact single word, then abort during a WRITE cycle.
    for (int i = 0; i < 14; i++) begin
      bus.start = vec[i].st; bus.word_count = vec[i].wc; bus.abort = vec[i].ab;
      bus.byte_in = vec[i].b; bus.byte_valid = vec[i].v;
      @(posedge clk);
      #1;
      chk($sformatf("vector %0d", i), outs(),
          {21'd0, vec[i].e_rdy, vec[i].e_wen, vec[i].e_addr, vec[i].e_data,
           vec[i].e_busy, vec[i].e_done, vec[i].e_busy});
      @(negedge clk);
    end
    idle_inputs();

    // Four words back-to-back.
    base = wq.size(); d0 = done_cnt;
    do_start(7'd4);
    for (int i = 0; i < 4; i++) send_word(words4[i], 0);
    wait_idle("four words");
    chk("four words write count", 64'(wq.size() - base), 64'd4);
    for (int i = 0; i < 4 && base + i < wq.size(); i++) begin
      chk($sformatf("four words addr %0d", i), 64'(wq[base+i].a), 64'(i));
      chk($sformatf("four words data %0d", i), 64'(wq[base+i].d), 64'(words4[i]));
    end
    chk("four words done count", 64'(done_cnt - d0), 64'd1);
    chk("done follows last write", 64'(done_cyc), 64'(last_wr_cyc + 1));
    chk("byte_ready low in WRITE", 64'(ovl_cnt), 64'd0);

    // Gapped valid.
    base = wq.size();
    do_start(7'd1);
    send_word(32'h00F0D193, 3);
    wait_idle("gapped");
    chk("gapped write count", 64'(wq.size() - base), 64'd1);
    if (wq.size() > base)
      chk("gapped write", {26'd0, wq[base].a, wq[base].d}, {26'd0, 6'd0, 32'h00F0D193});

    // word_count = 0.
    base = wq.size(); d0 = done_cnt;
    do_start(7'd0);
    chk("count0 fin busy/done", {62'd0, bus.busy, bus.done}, 64'b11);
    @(negedge clk);
    chk("count0 idle busy/done", {62'd0, bus.busy, bus.done}, 64'b00);
    chk("count0 no writes", 64'(wq.size() - base), 64'd0);
    chk("count0 done count", 64'(done_cnt - d0), 64'd1);

    // word_count = 100 clamps to 64.
    base = wq.size();
    do_start(7'd100);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] ib;
      ib = 8'(i);
      send_word({8'h5A, ~ib, 8'hA5, ib}, 0);
    end
    wait_idle("clamp");
    chk("clamp write count", 64'(wq.size() - base), 64'd64);
    for (int i = 0; i < 64 && base + i < wq.size(); i++) begin
      logic [7:0] ib;
      ib = 8'(i);
      chk($sformatf("clamp write %0d", i), {26'd0, wq[base+i].a, wq[base+i].d},
          {26'd0, 6'(i), 8'h5A, ~ib, 8'hA5, ib});
    end

    // start while busy is ignored.
    base = wq.size(); d0 = done_cnt;
    do_start(7'd2);
    send_word(32'h11111111, 0);
    bus.start = 1'b1; bus.word_count = 7'd5;
    send_byte(8'h22, 0);
    bus.start = 1'b0;
    send_byte(8'h22, 0); send_byte(8'h22, 0); send_byte(8'h22, 0);
    wait_idle("start while busy");
    chk("start while busy write count", 64'(wq.size() - base), 64'd2);
    chk("start while busy done count", 64'(done_cnt - d0), 64'd1);

    // Abort after 2 words plus 2 bytes.
    base = wq.size(); d0 = done_cnt;
    do_start(7'd4);
    send_word(words4[0], 0);
    send_word(words4[1], 0);
    send_byte(8'h93, 0); send_byte(8'hD1, 0);
    bus.byte_valid = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort busy", {62'd0, bus.busy, bus.cpu_hold}, 64'd0);
    repeat (6) @(negedge clk);
    chk("abort write count", 64'(wq.size() - base), 64'd2);
    if (wq.size() >= base + 2) begin
      chk("abort write 0", {26'd0, wq[base].a, wq[base].d}, {26'd0, 6'd0, words4[0]});
      chk("abort write 1", {26'd0, wq[base+1].a, wq[base+1].d}, {26'd0, 6'd1, words4[1]});
    end
    chk("abort no done", 64'(done_cnt - d0), 64'd0);
    base = wq.size();
    do_start(7'd1);
    send_word(32'h0020D213, 0);
    wait_idle("after abort");
    chk("after abort write count", 64'(wq.size() - base), 64'd1);
    if (wq.size() > base)
      chk("after abort write", {26'd0, wq[base].a, wq[base].d}, {26'd0, 6'd0, 32'h0020D213});

    // Reset mid-load after 2 bytes.
    do_start(7'd1);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    bus.byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("mid-load reset outputs", outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = wq.size();
    do_start(7'd1);
    send_word(32'h44332211, 0);
    wait_idle("after reset");
    chk("after reset write count", 64'(wq.size() - base), 64'd1);
    if (wq.size() > base)
      chk("after reset write", {26'd0, wq[base].a, wq[base].d}, {26'd0, 6'd0, 32'h44332211});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
